// File: rtl/team_06_pkg.sv
// Shared types and constants for the volume control slice.
package team_06_pkg;

  localparam int VOL_W = 4;
  localparam logic [VOL_W-1:0] VOL_MAX = 4'd15;

  typedef enum logic [2:0] {
    ACTIVE,
    RAMP,
    MUTE_RAMP,
    MUTED,
    UNMUTE_RAMP
  } vol_state_t;

endpackage

// File: rtl/team_06_btn_repeat.sv
// Button edge detector with hold-to-repeat; emits a registered one-cycle step pulse.
// The first step follows the rising edge; further steps after REPEAT_DELAY, then every REPEAT_RATE.
module team_06_btn_repeat #(
  parameter int REPEAT_DELAY = 500_000,
  parameter int REPEAT_RATE  = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic hold_off,
  output logic step
);

  localparam int CMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] DLY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(REPEAT_RATE - 1);

  logic          btn_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rep_q, rep_d;
  logic          step_q, step_d;

  // rep_q selects the repeat-rate interval once the initial delay has elapsed
  always_comb begin
    cnt_d  = '0;
    rep_d  = 1'b0;
    step_d = 1'b0;
    if (btn && !hold_off) begin
      if (!btn_prev_q) begin
        step_d = 1'b1;
      end else if (cnt_q == (rep_q ? RATE_LAST : DLY_LAST)) begin
        step_d = 1'b1;
        rep_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        rep_d = rep_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_prev_q <= 1'b0;
      cnt_q      <= '0;
      rep_q      <= 1'b0;
      step_q     <= 1'b0;
    end else begin
      btn_prev_q <= btn;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      step_q     <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/team_06_volume_ctrl.sv
// Turns up/down/mute buttons into a target volume and a sample-aligned one-step-at-a-time
// applied volume plus shifter enable; fades in from 0 after reset.
module team_06_volume_ctrl
  import team_06_pkg::*;
#(
  parameter int REPEAT_DELAY = 500_000,
  parameter int REPEAT_RATE  = 100_000,
  parameter int RAMP_TICKS   = 4,
  parameter int VOL_RESET    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_mute,
  input  logic             sample_tick,
  output logic [VOL_W-1:0] volume,
  output logic             enable_volume,
  output logic [VOL_W-1:0] target_vol,
  output logic             muted,
  output logic             busy
);

  localparam int TW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
  localparam logic [TW-1:0]    TICK_LAST  = TW'(RAMP_TICKS - 1);
  localparam logic [VOL_W-1:0] TARGET_RST = VOL_W'(VOL_RESET);

  logic             up_step, dn_step, hold_off;
  logic             mute_prev_q, mute_edge_q, mute_edge_d;
  logic [VOL_W-1:0] target_q, target_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic [VOL_W-1:0] goal;
  logic [TW-1:0]    tick_q, tick_d;
  vol_state_t       state_q, state_d;

  assign hold_off = btn_up & btn_down;

  team_06_btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_rep_up (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_up),
    .hold_off(hold_off),
    .step    (up_step)
  );

  team_06_btn_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE (REPEAT_RATE)
  ) u_rep_dn (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn_down),
    .hold_off(hold_off),
    .step    (dn_step)
  );

  // Mute edge is registered so it lines up with the registered volume steps
  assign mute_edge_d = btn_mute & ~mute_prev_q;

  always_comb begin
    target_d = target_q;
    if (up_step && !dn_step && target_q != VOL_MAX) begin
      target_d = target_q + 1'b1;
    end else if (dn_step && !up_step && target_q != '0) begin
      target_d = target_q - 1'b1;
    end
  end

  assign goal = (state_q == MUTE_RAMP || state_q == MUTED) ? '0 : target_q;

  always_comb begin
    vol_d  = vol_q;
    tick_d = tick_q;
    if (vol_q == goal) begin
      tick_d = '0;
    end else if (sample_tick) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        vol_d  = (vol_q < goal) ? vol_q + 1'b1 : vol_q - 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  // Goal checks use the post-edge volume so the state settles on the same edge as the last step
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACTIVE: begin
        if (mute_edge_q)                state_d = MUTE_RAMP;
        else if (target_d != target_q)  state_d = RAMP;
      end
      RAMP: begin
        if (mute_edge_q)                state_d = MUTE_RAMP;
        else if (vol_d == target_d)     state_d = ACTIVE;
      end
      MUTE_RAMP: begin
        if (mute_edge_q)                state_d = RAMP;
        else if (vol_d == '0)           state_d = MUTED;
      end
      MUTED: begin
        if (mute_edge_q)                state_d = UNMUTE_RAMP;
      end
      UNMUTE_RAMP: begin
        if (mute_edge_q)                state_d = MUTE_RAMP;
        else if (vol_d == target_d)     state_d = ACTIVE;
      end
      default:                          state_d = RAMP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mute_prev_q <= 1'b0;
      mute_edge_q <= 1'b0;
      target_q    <= TARGET_RST;
      vol_q       <= '0;
      tick_q      <= '0;
      state_q     <= RAMP;
    end else begin
      mute_prev_q <= btn_mute;
      mute_edge_q <= mute_edge_d;
      target_q    <= target_d;
      vol_q       <= vol_d;
      tick_q      <= tick_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    enable_volume = (state_q != MUTED);
    muted         = (state_q == MUTE_RAMP) || (state_q == MUTED);
    busy          = (state_q == RAMP) || (state_q == MUTE_RAMP) || (state_q == UNMUTE_RAMP);
  end

  assign volume     = vol_q;
  assign target_vol = target_q;

endmodule

// File: tb/tb_team_06_volume_ctrl.sv
// Directed bench for team_06_volume_ctrl; applied-volume steps are checked against a scoreboard queue.
module tb_team_06_volume_ctrl;
  import team_06_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_mute = 1'b0, sample_tick = 1'b0;
  logic [3:0] volume, target_vol;
  logic       enable_volume, muted, busy;

  int   nerr = 0;
  int   nchk = 0;
  int   exp_q[$];
  logic [3:0] vprev = 4'd0;
  logic tick_last = 1'b0;
  int   cyc_n = 0;
  int   last_cyc = 0;
  bit   gap_en = 1'b0;
  bit   have_last = 1'b0;
  int   vmin = 15;
  int   tick_phase = 0;

  team_06_volume_ctrl #(
    .REPEAT_DELAY(10),
    .REPEAT_RATE (4),
    .RAMP_TICKS  (2),
    .VOL_RESET   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_mute     (btn_mute),
    .sample_tick  (sample_tick),
    .volume       (volume),
    .enable_volume(enable_volume),
    .target_vol   (target_vol),
    .muted        (muted),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // sample_tick: one pulse every 5 cycles
  initial begin
    forever begin
      @(posedge clk); #2;
      sample_tick = (tick_phase == 4);
      tick_phase  = (tick_phase + 1) % 5;
    end
  end

  // Scoreboard: every change of volume must be the next expected value, on a tick edge
  always @(negedge clk) begin
    if (rst) begin
      vprev = volume;
    end else begin
      cyc_n++;
      if (volume !== vprev) begin
        check("sb_has_entry", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("vol_seq", volume, exp_q.pop_front());
        check("vol_on_tick", tick_last, 1);
        if (gap_en && have_last) check("ramp_gap", cyc_n - last_cyc, 10);
        have_last = 1'b1;
        last_cyc  = cyc_n;
        if (int'(volume) < vmin) vmin = int'(volume);
      end
      vprev = volume;
    end
    tick_last = sample_tick;
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push_range(input int from, input int to);
    if (from <= to) for (int v = from; v <= to; v++) exp_q.push_back(v);
    else            for (int v = from; v >= to; v--) exp_q.push_back(v);
  endtask

  task automatic press_mute();
    btn_mute = 1'b1; cyc(2); btn_mute = 1'b0; cyc(2);
  endtask

  task automatic press_down();
    btn_down = 1'b1; cyc(2); btn_down = 1'b0; cyc(2);
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < limit) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, n < limit, 1);
  endtask

  task automatic wait_queue(input string tag, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, n < limit, 1);
  endtask

  function automatic int rep_exp(input int i);
    int t;
    if (i < 2)       t = 8;
    else if (i < 12) t = 9;
    else             t = 10 + (i - 12) / 4;
    return (t > 15) ? 15 : t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    cyc(3);
    @(negedge clk);
    check("rst_volume", volume, 0);
    check("rst_target", target_vol, 8);
    check("rst_enable", enable_volume, 1);
    check("rst_muted", muted, 0);
    check("rst_busy", busy, 1);
    check("rst_state", 32'(dut.state_q), 32'(RAMP));

    // Fade-in from 0 to 8
    push_range(1, 8);
    gap_en = 1'b1; have_last = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    wait_done("fadein", 300);
    check("fadein_volume", volume, 8);
    check("fadein_busy", busy, 0);
    check("fadein_state", 32'(dut.state_q), 32'(ACTIVE));
    gap_en = 1'b0;

    // Hold up for 40 cycles: edge step, delayed repeat, rate repeats, saturation
    push_range(9, 15);
    btn_up = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #2;
      check("repeat_target", target_vol, rep_exp(i));
    end
    btn_up = 1'b0;
    wait_done("repeat", 400);
    check("sat_target", target_vol, 15);
    check("sat_volume", volume, 15);
    check("sat_state", 32'(dut.state_q), 32'(ACTIVE));

    // Back down to 8 with short presses
    push_range(14, 8);
    repeat (7) press_down();
    wait_done("down", 400);
    check("down_target", target_vol, 8);

    // Both buttons held: no steps
    btn_up = 1'b1; btn_down = 1'b1;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      check("both_target", target_vol, 8);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    cyc(15);
    check("both_after_target", target_vol, 8);
    check("both_busy", busy, 0);

    // Mute and unmute
    gap_en = 1'b1; have_last = 1'b0;
    push_range(7, 0);
    press_mute();
    wait_done("mute", 300);
    check("mute_volume", volume, 0);
    check("mute_enable", enable_volume, 0);
    check("mute_muted", muted, 1);
    check("mute_state", 32'(dut.state_q), 32'(MUTED));
    have_last = 1'b0;
    push_range(1, 8);
    press_mute();
    check("unmute_enable", enable_volume, 1);
    check("unmute_muted", muted, 0);
    check("unmute_busy", busy, 1);
    wait_done("unmute", 300);
    check("unmute_volume", volume, 8);
    check("unmute_state", 32'(dut.state_q), 32'(ACTIVE));
    gap_en = 1'b0;

    // Abort a mute ramp at volume 5
    vmin = 15;
    push_range(7, 5);
    press_mute();
    wait_queue("abort_reach5", 300);
    push_range(6, 8);
    btn_mute = 1'b1; cyc(2); btn_mute = 1'b0; cyc(2);
    wait_done("abort", 300);
    check("abort_min", vmin, 5);
    check("abort_volume", volume, 8);
    check("abort_state", 32'(dut.state_q), 32'(ACTIVE));

    // Change target while muted
    push_range(7, 0);
    press_mute();
    wait_done("mute2", 300);
    press_down();
    press_down();
    check("muted_target", target_vol, 6);
    check("muted_volume", volume, 0);
    check("muted_enable", enable_volume, 0);
    push_range(1, 6);
    press_mute();
    wait_done("unmute2", 300);
    check("unmute2_volume", volume, 6);
    check("unmute2_state", 32'(dut.state_q), 32'(ACTIVE));

    // Async reset while ramping at volume 3
    push_range(5, 0);
    press_mute();
    wait_done("mute3", 300);
    push_range(1, 3);
    press_mute();
    wait_queue("reach3", 300);
    check("pre_rst_busy", busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_volume", volume, 0);
    check("arst_target", target_vol, 8);
    check("arst_state", 32'(dut.state_q), 32'(RAMP));
    check("arst_busy", busy, 1);
    check("arst_enable", enable_volume, 1);
    exp_q.delete();
    cyc(2);
    push_range(1, 8);
    gap_en = 1'b1; have_last = 1'b0;
    rst = 1'b0;
    wait_done("refade", 300);
    check("refade_volume", volume, 8);
    check("refade_state", 32'(dut.state_q), 32'(ACTIVE));
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
